// File: rtl/apu_cluster_package.sv
// Shared APU cluster definitions: multiplier port widths and the
// result-pipeline entry used by the integer multiplier scheduler.
package apu_cluster_package;

  localparam int DSP_WIDTH         = 32;
  localparam int WOP_INT_MULT      = 2;
  localparam int NDSFLAGS_INT_MULT = 3;

  // Pipeline id/tag fields are sized for the largest supported cluster
  // and zero-extended from the actual requester id and tag.
  localparam int PIPE_ID_W  = 8;
  localparam int PIPE_TAG_W = 8;

  typedef enum logic [WOP_INT_MULT-1:0] {
    INT_MULT_MUL  = 2'd0,
    INT_MULT_MAC  = 2'd1,
    INT_MULT_MULH = 2'd2,
    INT_MULT_MSU  = 2'd3
  } int_mult_op_e;

  typedef struct packed {
    logic                  valid;
    logic [PIPE_ID_W-1:0]  id;
    logic [PIPE_TAG_W-1:0] tag;
    logic [DSP_WIDTH-1:0]  res;
  } int_mult_pipe_t;

endpackage

// File: rtl/apu_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after prio_ptr,
// then moves prio_ptr just past the winner.
module apu_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] Req,
  input  logic               En,
  output logic [NUM_REQ-1:0] Gnt,
  output logic [IDX_W-1:0]   GntIdx,
  output logic               GntValid
);

  logic [IDX_W-1:0] prio_ptr_q, prio_ptr_d;

  always_comb begin : arb_search
    int k;
    k          = 0;
    Gnt        = '0;
    GntIdx     = '0;
    GntValid   = 1'b0;
    prio_ptr_d = prio_ptr_q;
    if (En) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        k = int'(prio_ptr_q) + i;
        if (k >= NUM_REQ) k = k - NUM_REQ;
        if (!GntValid && Req[k]) begin
          GntValid = 1'b1;
          GntIdx   = IDX_W'(k);
        end
      end
    end
    if (GntValid) begin
      Gnt[GntIdx] = 1'b1;
      prio_ptr_d  = (int'(GntIdx) == NUM_REQ - 1) ? '0 : GntIdx + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) prio_ptr_q <= '0;
    else       prio_ptr_q <= prio_ptr_d;
  end

endmodule

// File: rtl/int_mult_sched.sv
// Shares one combinational integer multiplier among NUM_REQ requesters and
// returns each result with its tag through a LATENCY-deep result pipeline.
module int_mult_sched
  import apu_cluster_package::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int TAG_WIDTH = 2,
  parameter int LATENCY   = 2
) (
  input  logic                                            clk_i,
  input  logic                                            rst_i,
  input  logic [NUM_REQ-1:0]                              Req_i,
  output logic [NUM_REQ-1:0]                              Gnt_o,
  input  logic [NUM_REQ-1:0][WOP_INT_MULT-1:0]            Op_i,
  input  logic [NUM_REQ-1:0][DSP_WIDTH-1:0]               OpA_i,
  input  logic [NUM_REQ-1:0][DSP_WIDTH-1:0]               OpB_i,
  input  logic [NUM_REQ-1:0][DSP_WIDTH-1:0]               OpC_i,
  input  logic [NUM_REQ-1:0][NDSFLAGS_INT_MULT-1:0]       Flags_i,
  input  logic [NUM_REQ-1:0][TAG_WIDTH-1:0]               Tag_i,
  output logic [NUM_REQ-1:0]                              RValid_o,
  output logic [DSP_WIDTH-1:0]                            RData_o,
  output logic [TAG_WIDTH-1:0]                            RTag_o,
  input  logic [NUM_REQ-1:0]                              RAck_i,
  output logic                                            MultEn_o,
  output logic [WOP_INT_MULT-1:0]                         MultOp_o,
  output logic [DSP_WIDTH-1:0]                            MultOpA_o,
  output logic [DSP_WIDTH-1:0]                            MultOpB_o,
  output logic [DSP_WIDTH-1:0]                            MultOpC_o,
  output logic [NDSFLAGS_INT_MULT-1:0]                    MultFlags_o,
  input  logic [DSP_WIDTH-1:0]                            MultRes_i
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  int_mult_pipe_t  pipe_q [LATENCY];
  int_mult_pipe_t  pipe_d [LATENCY];
  logic [ID_W-1:0] head_id;
  logic [ID_W-1:0] gnt_idx;
  logic            gnt_valid;
  logic            head_valid;
  logic            stall;

  assign head_valid = pipe_q[LATENCY-1].valid;
  assign head_id    = pipe_q[LATENCY-1].id[ID_W-1:0];
  assign stall      = head_valid & ~RAck_i[head_id];

  // Reset also blocks arbitration so nothing is issued during the flush.
  apu_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(ID_W)) u_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .Req      (Req_i),
    .En       (~stall & ~rst_i),
    .Gnt      (Gnt_o),
    .GntIdx   (gnt_idx),
    .GntValid (gnt_valid)
  );

  always_comb begin
    MultEn_o    = gnt_valid;
    MultOp_o    = '0;
    MultOpA_o   = '0;
    MultOpB_o   = '0;
    MultOpC_o   = '0;
    MultFlags_o = '0;
    if (gnt_valid) begin
      MultOp_o    = Op_i[gnt_idx];
      MultOpA_o   = OpA_i[gnt_idx];
      MultOpB_o   = OpB_i[gnt_idx];
      MultOpC_o   = OpC_i[gnt_idx];
      MultFlags_o = Flags_i[gnt_idx];
    end
  end

  // Bubbles enter with zero payload so an idle head presents zero data.
  always_comb begin
    for (int i = 0; i < LATENCY; i++) pipe_d[i] = pipe_q[i];
    if (!stall) begin
      pipe_d[0]       = '0;
      pipe_d[0].valid = gnt_valid;
      if (gnt_valid) begin
        pipe_d[0].id  = PIPE_ID_W'(gnt_idx);
        pipe_d[0].tag = PIPE_TAG_W'(Tag_i[gnt_idx]);
        pipe_d[0].res = MultRes_i;
      end
      for (int i = 1; i < LATENCY; i++) pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < LATENCY; i++) begin
      if (rst_i) pipe_q[i] <= '0;
      else       pipe_q[i] <= pipe_d[i];
    end
  end

  always_comb begin
    RValid_o = '0;
    if (head_valid) RValid_o[head_id] = 1'b1;
  end

  assign RData_o = pipe_q[LATENCY-1].res;
  assign RTag_o  = pipe_q[LATENCY-1].tag[TAG_WIDTH-1:0];

endmodule

// File: tb/tb_int_mult_sched.sv
// Directed bench for int_mult_sched: LATENCY=2 instance for arbitration,
// backpressure and reset; LATENCY=1 instance for short latency and stray acks.
module tb_int_mult_sched;
  import apu_cluster_package::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // LATENCY=2 instance signals
  logic [3:0]                              req, gnt, rvalid, rack;
  logic [3:0][WOP_INT_MULT-1:0]            op;
  logic [3:0][DSP_WIDTH-1:0]               opa, opb, opc;
  logic [3:0][NDSFLAGS_INT_MULT-1:0]       flags;
  logic [3:0][1:0]                         tag;
  logic [DSP_WIDTH-1:0]                    rdata, mult_opa, mult_opb, mult_opc, mult_res;
  logic [1:0]                              rtag;
  logic                                    mult_en;
  logic [WOP_INT_MULT-1:0]                 mult_op;
  logic [NDSFLAGS_INT_MULT-1:0]            mult_flags;

  // LATENCY=1 instance signals
  logic [3:0]                              req1, gnt1, rvalid1, rack1;
  logic [3:0][WOP_INT_MULT-1:0]            op1;
  logic [3:0][DSP_WIDTH-1:0]               opa1, opb1, opc1;
  logic [3:0][NDSFLAGS_INT_MULT-1:0]       flags1;
  logic [3:0][1:0]                         tag1;
  logic [DSP_WIDTH-1:0]                    rdata1, mult_opa1, mult_opb1, mult_opc1, mult_res1;
  logic [1:0]                              rtag1;
  logic                                    mult_en1;
  logic [WOP_INT_MULT-1:0]                 mult_op1;
  logic [NDSFLAGS_INT_MULT-1:0]            mult_flags1;

  // Multiplier model: unsigned product at DSP_WIDTH
  assign mult_res  = mult_opa * mult_opb;
  assign mult_res1 = mult_opa1 * mult_opb1;

  int_mult_sched #(.NUM_REQ(4), .TAG_WIDTH(2), .LATENCY(2)) u_dut (
    .clk_i(clk), .rst_i(rst), .Req_i(req), .Gnt_o(gnt), .Op_i(op),
    .OpA_i(opa), .OpB_i(opb), .OpC_i(opc), .Flags_i(flags), .Tag_i(tag),
    .RValid_o(rvalid), .RData_o(rdata), .RTag_o(rtag), .RAck_i(rack),
    .MultEn_o(mult_en), .MultOp_o(mult_op), .MultOpA_o(mult_opa),
    .MultOpB_o(mult_opb), .MultOpC_o(mult_opc), .MultFlags_o(mult_flags),
    .MultRes_i(mult_res)
  );

  int_mult_sched #(.NUM_REQ(4), .TAG_WIDTH(2), .LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .Req_i(req1), .Gnt_o(gnt1), .Op_i(op1),
    .OpA_i(opa1), .OpB_i(opb1), .OpC_i(opc1), .Flags_i(flags1), .Tag_i(tag1),
    .RValid_o(rvalid1), .RData_o(rdata1), .RTag_o(rtag1), .RAck_i(rack1),
    .MultEn_o(mult_en1), .MultOp_o(mult_op1), .MultOpA_o(mult_opa1),
    .MultOpB_o(mult_opb1), .MultOpC_o(mult_opc1), .MultFlags_o(mult_flags1),
    .MultRes_i(mult_res1)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_pop    = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [1:0] t);
    opa[i] = a; opb[i] = b; tag[i] = t;
  endtask

  task automatic set_op1(input int i, input logic [31:0] a, input logic [31:0] b, input logic [1:0] t);
    opa1[i] = a; opb1[i] = b; tag1[i] = t;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; rack = '0; req1 = '0; rack1 = '0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = '0; rack = '0; op = '0; opa = '0; opb = '0; opc = '0; flags = '0; tag = '0;
    req1 = '0; rack1 = '0; op1 = '0; opa1 = '0; opb1 = '0; opc1 = '0; flags1 = '0; tag1 = '0;
    step();

    // reset state, and grant suppressed while reset is high
    req = 4'b0001; set_op(0, 3, 5, 2'b10);
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_en", mult_en, 0);
    check("rst_opa", mult_opa, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rtag", rtag, 0);
    step();

    // single request: 3*5 tag 10
    rst = 1'b0;
    #1;
    check("t1_gnt", gnt, 4'b0001);
    check("t1_en", mult_en, 1);
    check("t1_opa", mult_opa, 3);
    check("t1_opb", mult_opb, 5);
    step(); req = '0; #1;
    check("t1_rvalid_t1", rvalid, 0);
    step(); #1;
    check("t1_rvalid", rvalid, 4'b0001);
    check("t1_rdata", rdata, 15);
    check("t1_rtag", rtag, 2'b10);
    rack = 4'b0001;
    step(); rack = '0; #1;
    check("t1_rvalid_after_ack", rvalid, 0);

    // round robin with continuous ack
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, i + 1, 10, 2'(i));
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      req  = (k < 6) ? 4'b1111 : 4'b0000;
      rack = 4'b1111;
      #1;
      check("rr_gnt", gnt, (k < 6) ? (64'd1 << (k % 4)) : 64'd0);
      if (k >= 2) begin
        check("rr_rvalid", rvalid, 64'd1 << ((k - 2) % 4));
        check("rr_rdata", rdata, ((k - 2) % 4 + 1) * 10);
        check("rr_rtag", rtag, (k - 2) % 4);
      end
    end
    step(); req = '0; rack = '0; #1;
    check("rr_drain", rvalid, 0);

    // backpressure, then ack releasing the stall in the cycle a request rises
    do_reset();
    set_op(3, 4, 10, 2'd3);
    req = 4'b0011; #1;
    check("bp_gnt0", gnt, 4'b0001);
    step(); req = 4'b0010; #1;
    check("bp_gnt1", gnt, 4'b0010);
    for (int c = 0; c < 3; c++) begin
      step(); req = 4'b1000; #1;
      check("bp_stall_gnt", gnt, 0);
      check("bp_stall_rvalid", rvalid, 4'b0001);
      check("bp_stall_rdata", rdata, 10);
      check("bp_stall_rtag", rtag, 0);
    end
    step(); req = 4'b1100; rack = 4'b0001; #1;
    check("ack_issue_gnt", gnt, 4'b0100);
    if ((rvalid & rack) != 0) n_pop++;
    step(); req = 4'b1000; rack = 4'b0010; #1;
    check("bp_gnt3", gnt, 4'b1000);
    check("bp_res1", rdata, 20);
    if ((rvalid & rack) != 0) n_pop++;
    step(); req = '0; rack = 4'b0100; #1;
    check("bp_res2", rdata, 30);
    if ((rvalid & rack) != 0) n_pop++;
    step(); rack = 4'b1000; #1;
    check("bp_res3", rdata, 40);
    check("bp_tag3", rtag, 3);
    if ((rvalid & rack) != 0) n_pop++;
    step(); rack = '0; #1;
    check("bp_drain", rvalid, 0);
    check("bp_popped", n_pop, 4);

    // reset with two operations in flight
    do_reset();
    req = 4'b0001; set_op(0, 7, 3, 2'd1); #1;
    check("rs_gnt0", gnt, 4'b0001);
    step(); req = 4'b0010; set_op(1, 9, 9, 2'd2); #1;
    check("rs_gnt1", gnt, 4'b0010);
    step(); rst = 1'b1; req = 4'b0100; rack = 4'b1111; #1;
    check("rs_gnt_forced", gnt, 0);
    check("rs_en_forced", mult_en, 0);
    step(); rst = 1'b0; rack = '0; req = 4'b0101; set_op(2, 4, 4, 2'd3); #1;
    check("rs_rvalid", rvalid, 0);
    check("rs_rdata", rdata, 0);
    check("rs_rtag", rtag, 0);
    check("rs_gnt_ptr0", gnt, 4'b0001);
    step(); req = 4'b0100; #1;
    check("rs_flushed", rvalid, 0);
    check("rs_gnt2", gnt, 4'b0100);
    step(); req = '0; #1;
    check("rs_res0_v", rvalid, 4'b0001);
    check("rs_res0_d", rdata, 21);
    check("rs_res0_t", rtag, 1);
    rack = 4'b0001;
    step(); #1;
    check("rs_res2_v", rvalid, 4'b0100);
    check("rs_res2_d", rdata, 16);
    rack = 4'b0100;
    step(); rack = '0; #1;
    check("rs_drain", rvalid, 0);

    // LATENCY=1 instance: wide result and stray acks
    req1 = 4'b0001; set_op1(0, 32'hFFFF_FFFF, 2, 2'd3); #1;
    check("l1_gnt0", gnt1, 4'b0001);
    step(); req1 = 4'b0010; set_op1(1, 6, 7, 2'd1); rack1 = 4'b1010; #1;
    check("l1_rvalid", rvalid1, 4'b0001);
    check("l1_rdata", rdata1, 32'hFFFF_FFFE);
    check("l1_rtag", rtag1, 3);
    check("l1_stray_gnt", gnt1, 0);
    step(); rack1 = 4'b0001; #1;
    check("l1_not_popped", rvalid1, 4'b0001);
    check("l1_hold_data", rdata1, 32'hFFFF_FFFE);
    check("l1_gnt1", gnt1, 4'b0010);
    step(); req1 = '0; rack1 = 4'b0010; #1;
    check("l1_res1_v", rvalid1, 4'b0010);
    check("l1_res1_d", rdata1, 42);
    check("l1_res1_t", rtag1, 1);
    step(); rack1 = '0; #1;
    check("l1_drain", rvalid1, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
